// File: rtl/fibonacci_pkg.sv
// Shared types and helpers for the Fibonacci stream checker.
package fibonacci_pkg;

    localparam int FIB_W  = 32;
    localparam int FIB_CW = 16;

    typedef enum logic [1:0] {
        SEED0 = 2'd0,
        SEED1 = 2'd1,
        TRACK = 2'd2,
        FAULT = 2'd3
    } fib_state_e;

    // Increment that holds at max_v; callers zero-extend narrower counters.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max_v);
        return (v == max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/fib_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module fib_sat_counter
    import fibonacci_pkg::*;
#(
    parameter int CW = FIB_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [CW-1:0] o_count
);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_max;

    assign w_max = {CW{1'b1}};

    // Count register: sticks at all-ones once reached.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= {CW{1'b0}};
        end else if (i_inc) begin
            r_count <= CW'(sat_inc(64'(r_count), 64'(w_max)));
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fibonacci_checker.sv
// Locks onto two seed words, then checks each word against the sum of the previous two.
// Optional: define FIB_CHECK_RESYNC_EN to reseed on mismatch instead of stalling in FAULT.
module fibonacci_checker
    import fibonacci_pkg::*;
#(
    parameter int W  = FIB_W,
    parameter int CW = FIB_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    input  logic          clear,
    output logic          locked,
    output logic          err,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] term_count,
    output logic          wrapped,
    output logic [W-1:0]  last_expected
);

    fib_state_e    r_state;
    fib_state_e    w_state_nxt;
    logic [W-1:0]  r_p1;
    logic [W-1:0]  r_p0;
    logic [W-1:0]  w_p1_nxt;
    logic [W-1:0]  w_p0_nxt;
    logic          r_in_ready;
    logic          r_locked;
    logic          r_err;
    logic          r_wrapped;
    logic [W-1:0]  r_last_expected;
    logic          w_accept;
    logic [W:0]    w_sum;
    logic [W-1:0]  w_expected;
    logic          w_carry;
    logic          w_track_acc;
    logic          w_term_inc;
    logic          w_err_inc;

    assign w_accept   = in_valid && r_in_ready;
    assign w_sum      = {1'b0, r_p0} + {1'b0, r_p1};
    assign w_expected = w_sum[W-1:0];
    assign w_carry    = w_sum[W];

    // Next-state and datapath decode; every transition needs an accepted word.
    always_comb begin
        w_state_nxt = r_state;
        w_p1_nxt    = r_p1;
        w_p0_nxt    = r_p0;
        w_track_acc = 1'b0;
        w_term_inc  = 1'b0;
        w_err_inc   = 1'b0;
        case (r_state)
            SEED0: begin
                if (w_accept) begin
                    w_p1_nxt    = in_data;
                    w_state_nxt = SEED1;
                end else begin
                    w_state_nxt = SEED0;
                end
            end
            SEED1: begin
                if (w_accept) begin
                    w_p0_nxt    = in_data;
                    w_state_nxt = TRACK;
                end else begin
                    w_state_nxt = SEED1;
                end
            end
            TRACK: begin
                if (w_accept) begin
                    w_track_acc = 1'b1;
                    if (in_data == w_expected) begin
                        w_term_inc = 1'b1;
                        w_p1_nxt   = r_p0;
                        w_p0_nxt   = in_data;
                    end else begin
                        w_err_inc = 1'b1;
`ifdef FIB_CHECK_RESYNC_EN
                        // The offending word becomes seed 0 of a fresh lock attempt.
                        w_p1_nxt    = in_data;
                        w_state_nxt = SEED1;
`else
                        w_state_nxt = FAULT;
`endif
                    end
                end else begin
                    w_state_nxt = TRACK;
                end
            end
            FAULT: begin
                w_state_nxt = FAULT;
            end
            default: begin
                w_state_nxt = SEED0;
            end
        endcase
    end

    // State, seeds and sticky flags; ready/locked are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state         <= SEED0;
            r_p1            <= {W{1'b0}};
            r_p0            <= {W{1'b0}};
            r_in_ready      <= 1'b1;
            r_locked        <= 1'b0;
            r_err           <= 1'b0;
            r_wrapped       <= 1'b0;
            r_last_expected <= {W{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_p1       <= w_p1_nxt;
            r_p0       <= w_p0_nxt;
            r_in_ready <= (w_state_nxt != FAULT);
            r_locked   <= (w_state_nxt == TRACK);
            r_err      <= r_err || w_err_inc;
            r_wrapped  <= r_wrapped || (w_track_acc && w_carry);
            if (w_track_acc) begin
                r_last_expected <= w_expected;
            end
        end
    end

    fib_sat_counter #(.CW(CW)) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (clear),
        .i_inc   (w_err_inc),
        .o_count (err_count)
    );

    fib_sat_counter #(.CW(CW)) u_term_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (clear),
        .i_inc   (w_term_inc),
        .o_count (term_count)
    );

    assign in_ready      = r_in_ready;
    assign locked        = r_locked;
    assign err           = r_err;
    assign wrapped       = r_wrapped;
    assign last_expected = r_last_expected;

endmodule

// File: tb/tb_fibonacci_checker.sv
// Directed bench: a 32-bit checker and an 8-bit checker with 2-bit counters for wrap/saturation.
module tb_fibonacci_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        locked;
    logic        err;
    logic [15:0] err_count;
    logic [15:0] term_count;
    logic        wrapped;
    logic [31:0] last_expected;

    logic        v8;
    logic [7:0]  d8;
    logic        rdy8;
    logic        lck8;
    logic        err8;
    logic [1:0]  ec8;
    logic [1:0]  tc8;
    logic        wr8;
    logic [7:0]  le8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fibonacci_checker #(.W(32), .CW(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .clear(clear), .locked(locked), .err(err), .err_count(err_count),
        .term_count(term_count), .wrapped(wrapped), .last_expected(last_expected)
    );

    fibonacci_checker #(.W(8), .CW(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_data(d8), .in_ready(rdy8),
        .clear(clear), .locked(lck8), .err(err8), .err_count(ec8),
        .term_count(tc8), .wrapped(wr8), .last_expected(le8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push8(input logic [7:0] d);
        v8 = 1'b1;
        d8 = d;
        @(negedge clk);
        v8 = 1'b0;
    endtask

    task automatic idle(input logic [31:0] junk);
        in_valid = 1'b0;
        in_data  = junk;
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_locked"}, 64'(locked), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_errcnt"}, 64'(err_count), 64'd0);
        chk({tag, "_termcnt"}, 64'(term_count), 64'd0);
        chk({tag, "_wrapped"}, 64'(wrapped), 64'd0);
        chk({tag, "_lastexp"}, 64'(last_expected), 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        v8       = 1'b0;
        d8       = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("reset");

        // Continuous generator stream.
        push(32'd0);
        chk("seed0_locked", 64'(locked), 64'd0);
        push(32'd1);
        chk("seed1_locked", 64'(locked), 64'd1);
        push(32'd1); push(32'd2); push(32'd3); push(32'd5); push(32'd8); push(32'd13);
        chk("gen_term", 64'(term_count), 64'd6);
        chk("gen_err", 64'(err), 64'd0);
        chk("gen_errcnt", 64'(err_count), 64'd0);
        chk("gen_wrapped", 64'(wrapped), 64'd0);
        chk("gen_lastexp", 64'(last_expected), 64'd13);
        chk("gen_locked", 64'(locked), 64'd1);

        // Corrupted stream: 8 replaced by 9.
        pulse_clear();
        chk_reset_vals("clear1");
        push(32'd0); push(32'd1); push(32'd1); push(32'd2); push(32'd3); push(32'd5); push(32'd9);
        chk("bad_err", 64'(err), 64'd1);
        chk("bad_errcnt", 64'(err_count), 64'd1);
        chk("bad_term", 64'(term_count), 64'd4);
        chk("bad_lastexp", 64'(last_expected), 64'd8);
        chk("bad_locked", 64'(locked), 64'd0);
`ifdef FIB_CHECK_RESYNC_EN
        chk("bad_ready", 64'(in_ready), 64'd1);
`else
        chk("bad_ready", 64'(in_ready), 64'd0);
        push(32'd13);
        chk("fault_stall_term", 64'(term_count), 64'd4);
        chk("fault_stall_errcnt", 64'(err_count), 64'd1);
        chk("fault_stall_ready", 64'(in_ready), 64'd0);
`endif
        pulse_clear();
        chk_reset_vals("clear2");

        // Reset in the middle of a stream discards the lock.
        push(32'd0); push(32'd1); push(32'd1); push(32'd2); push(32'd3);
        chk("mid_term_pre", 64'(term_count), 64'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("midrst");
        push(32'd7); push(32'd4); push(32'd11);
        chk("reseed_locked", 64'(locked), 64'd1);
        chk("reseed_term", 64'(term_count), 64'd1);
        chk("reseed_lastexp", 64'(last_expected), 64'd11);

        // Gapped feed with junk data while in_valid is low.
        pulse_clear();
        idle(32'd99);
        chk("gap_idle_locked", 64'(locked), 64'd0);
        push(32'd0); idle(32'd55); push(32'd1); idle(32'd77); push(32'd1); idle(32'd66); push(32'd2);
        chk("gap_term", 64'(term_count), 64'd2);
        chk("gap_errcnt", 64'(err_count), 64'd0);
        chk("gap_lastexp", 64'(last_expected), 64'd2);

`ifdef FIB_CHECK_RESYNC_EN
        // Mismatch reseeds instead of stalling.
        pulse_clear();
        push(32'd0); chk("rs_ready0", 64'(in_ready), 64'd1);
        push(32'd1); chk("rs_ready1", 64'(in_ready), 64'd1);
        push(32'd1); chk("rs_ready2", 64'(in_ready), 64'd1);
        push(32'd7); chk("rs_ready3", 64'(in_ready), 64'd1);
        chk("rs_locked_after7", 64'(locked), 64'd0);
        push(32'd3); chk("rs_ready4", 64'(in_ready), 64'd1);
        push(32'd10); chk("rs_ready5", 64'(in_ready), 64'd1);
        chk("rs_errcnt", 64'(err_count), 64'd1);
        chk("rs_term", 64'(term_count), 64'd2);
        chk("rs_locked", 64'(locked), 64'd1);
`endif

        // 8-bit checker: wrap-around and 2-bit counter saturation.
        pulse_clear();
        push8(8'd144); push8(8'd233);
        chk("w8_seed_wrapped", 64'(wr8), 64'd0);
        push8(8'd121);
        chk("w8_wrapped", 64'(wr8), 64'd1);
        chk("w8_lastexp", 64'(le8), 64'd121);
        chk("w8_term", 64'(tc8), 64'd1);
        chk("w8_err", 64'(err8), 64'd0);
        push8(8'd98); push8(8'd219);
        chk("w8_term3", 64'(tc8), 64'd3);
        push8(8'd61);
        chk("w8_term_sat", 64'(tc8), 64'd3);
        chk("w8_lastexp2", 64'(le8), 64'd61);
        chk("w8_locked", 64'(lck8), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
